// File: rtl/logs_pkg.sv
// Shared constants and helpers for the divider bank.
package logs_pkg;

  // Default divisor/counter width.
  localparam int W_DEF = 16;

  // Default divisor loaded into every channel at reset.
  localparam int DIV_RST_DEF = 2;

  // Address width for n channels; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logs_divider_chan.sv
// One divider channel: counter, active/pending divisor, registered tick and
// square wave. Pending divisors are promoted only at a wrap so a period in
// flight always completes with the divisor it started with.
module logs_divider_chan #(
  parameter int W       = logs_pkg::W_DEF,
  parameter int DIV_RST = logs_pkg::DIV_RST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         sync,
  output logic         tick,
  output logic         sq
);

  logic [W-1:0] cnt;
  logic [W-1:0] div_act;
  logic [W-1:0] div_pend;
  logic         pend_vld;
  logic [W-1:0] deff;
  logic         wrap;

  // Divisor 0 behaves as 1; ">=" lets a counter left beyond a freshly
  // loaded smaller divisor wrap on the next enabled edge.
  always_comb begin
    deff = (div_act == '0) ? W'(1) : div_act;
    wrap = (cnt >= (deff - W'(1)));
  end

  // Channel state update: reset, then sync, then disabled load/hold, then count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_act  <= W'(DIV_RST);
      div_pend <= '0;
      pend_vld <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else if (sync) begin
      cnt      <= '0;
      tick     <= 1'b0;
      sq       <= 1'b0;
      pend_vld <= 1'b0;
      if (wr) begin
        div_act <= wr_data;
      end else if (pend_vld) begin
        div_act <= div_pend;
      end
    end else if (!en) begin
      tick <= 1'b0;
      if (wr) begin
        div_act  <= wr_data;
        pend_vld <= 1'b0;
        cnt      <= '0;
      end
    end else begin
      tick <= (cnt == '0);
      if (cnt == '0) begin
        sq <= ~sq;
      end
      if (wrap) begin
        cnt <= '0;
        if (pend_vld) begin
          div_act  <= div_pend;
          pend_vld <= 1'b0;
        end
      end else begin
        cnt <= cnt + W'(1);
      end
      // A write landing on a wrap edge queues behind the promotion above.
      if (wr) begin
        div_pend <= wr_data;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/logs_divider_bank.sv
// Bank of NCH independent programmable clock dividers sharing one divisor
// write port and one global realignment strobe.
module logs_divider_bank
  import logs_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int W       = W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            en,
  input  logic                      wr_en,
  input  logic [addr_w(NCH)-1:0]    wr_addr,
  input  logic [W-1:0]              wr_data,
  input  logic                      sync,
  output logic [NCH-1:0]            tick,
  output logic [NCH-1:0]            sq
);

  localparam int AW = addr_w(NCH);

  logic [NCH-1:0] wr_ch;

  // Address decode; addresses at or beyond NCH match no channel.
  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_ch[i] = wr_en && (wr_addr == AW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logs_divider_chan #(
      .W       (W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .wr      (wr_ch[g]),
      .wr_data (wr_data),
      .sync    (sync),
      .tick    (tick[g]),
      .sq      (sq[g])
    );
  end

endmodule

// File: tb/tb_logs_divider_bank.sv
// Self-checking bench for logs_divider_bank with a per-channel reference model.
module tb_logs_divider_bank;

  localparam int NCH = 4;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [1:0]     wr_addr;
  logic [W-1:0]   wr_data;
  logic           sync;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  int checks   = 0;
  int failures = 0;

  // Reference model state: phase position, active/pending divisor, outputs.
  int             m_cnt  [NCH];
  int             m_act  [NCH];
  int             m_pend [NCH];
  bit             m_pv   [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;

  logs_divider_bank #(.NCH(NCH), .W(W), .DIV_RST(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sync    (sync),
    .tick    (tick),
    .sq      (sq)
  );

  always #5 clk = ~clk;

  // Apply the documented per-channel rules for one rising edge.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit w;
      int d;
      bit at_end;
      w = wr_en && (int'(wr_addr) == c);
      if (rst) begin
        m_cnt[c] = 0; m_act[c] = 2; m_pend[c] = 0; m_pv[c] = 0;
        m_tick[c] = 0; m_sq[c] = 0;
      end else if (sync) begin
        m_cnt[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
        if (w) m_act[c] = int'(wr_data);
        else if (m_pv[c]) m_act[c] = m_pend[c];
        m_pv[c] = 0;
      end else if (!en[c]) begin
        m_tick[c] = 0;
        if (w) begin
          m_act[c] = int'(wr_data); m_pv[c] = 0; m_cnt[c] = 0;
        end
      end else begin
        d = (m_act[c] < 1) ? 1 : m_act[c];
        m_tick[c] = (m_cnt[c] == 0);
        if (m_cnt[c] == 0) m_sq[c] = ~m_sq[c];
        at_end = (m_cnt[c] >= d - 1);
        m_cnt[c] = at_end ? 0 : m_cnt[c] + 1;
        if (at_end && m_pv[c]) begin
          m_act[c] = m_pend[c]; m_pv[c] = 0;
        end
        if (w) begin
          m_pend[c] = int'(wr_data); m_pv[c] = 1;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; sync = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = '0; idle_inputs();
    step();
    checks++;
    if (tick !== 4'h0) begin failures++; $display("FAIL reset_tick got=%h want=0", tick); end
    checks++;
    if (sq !== 4'h0) begin failures++; $display("FAIL reset_sq got=%h want=0", sq); end
    rst = 0; en = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      logic et, es;
      step();
      et = (i % 2 == 1);
      es = (((i - 1) / 2) % 2 == 0);
      checks++;
      if (tick[0] !== et) begin failures++; $display("FAIL d2_tick0 cyc=%0d got=%b want=%b", i, tick[0], et); end
      checks++;
      if (sq[0] !== es) begin failures++; $display("FAIL d2_sq0 cyc=%0d got=%b want=%b", i, sq[0], es); end
      checks++;
      if (tick !== m_tick) begin failures++; $display("FAIL d2_tick_all cyc=%0d got=%h want=%h", i, tick, m_tick); end
    end
  endtask

  task automatic test_pending_writes();
    int last1, last2;
    step();                                   // edge 9: D=2 counters sit at cnt=1
    wr_en = 1; wr_addr = 2; wr_data = 3;
    step();                                   // edge 10 wraps; D=3 queued for ch2
    wr_data = 7;
    step();                                   // edge 11: overwrite with D=7
    wr_en = 0;
    step();                                   // edge 12: 7 promoted
    wr_en = 1; wr_addr = 1; wr_data = 5;
    step();                                   // edge 13: ch1 queued mid-period
    wr_en = 0;
    last1 = -1; last2 = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (tick !== m_tick || sq !== m_sq) begin
        failures++;
        $display("FAIL pend_model i=%0d tick=%h/%h sq=%h/%h", i, tick, m_tick, sq, m_sq);
      end
      if (i >= 4 && tick[1]) begin
        if (last1 >= 0) begin
          checks++;
          if (i - last1 != 5) begin failures++; $display("FAIL ch1_period got=%0d want=5", i - last1); end
        end
        last1 = i;
      end
      if (tick[2]) begin
        if (last2 >= 0) begin
          checks++;
          if (i - last2 != 7) begin failures++; $display("FAIL ch2_period got=%0d want=7", i - last2); end
        end
        last2 = i;
      end
    end
  endtask

  task automatic test_sync();
    wr_en = 1; wr_addr = 0; wr_data = 3;
    step();
    wr_en = 0;
    for (int i = 0; i < 7; i++) step();
    sync = 1;
    step();
    sync = 0;
    checks++;
    if (tick !== 4'h0) begin failures++; $display("FAIL sync_tick0 got=%h want=0", tick); end
    checks++;
    if (sq !== 4'h0) begin failures++; $display("FAIL sync_sq got=%h want=0", sq); end
    step();
    checks++;
    if (tick !== 4'hF) begin failures++; $display("FAIL sync_tick1 got=%h want=f", tick); end
    checks++;
    if (sq !== 4'hF) begin failures++; $display("FAIL sync_sq1 got=%h want=f", sq); end
  endtask

  task automatic test_enable_hold();
    logic sq3;
    for (int i = 0; i < 3; i++) step();
    sq3 = sq[3];
    en[3] = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tick[3] !== 1'b0) begin failures++; $display("FAIL hold_tick3 i=%0d got=%b want=0", i, tick[3]); end
      checks++;
      if (sq[3] !== sq3) begin failures++; $display("FAIL hold_sq3 i=%0d got=%b want=%b", i, sq[3], sq3); end
    end
    en[3] = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (tick !== m_tick || sq !== m_sq) begin
        failures++;
        $display("FAIL resume_model i=%0d tick=%h/%h sq=%h/%h", i, tick, m_tick, sq, m_sq);
      end
    end
    en[3] = 0; wr_en = 1; wr_addr = 3; wr_data = 0;
    step();
    wr_en = 0; en[3] = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tick[3] !== 1'b1) begin failures++; $display("FAIL d0_tick3 i=%0d got=%b want=1", i, tick[3]); end
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) step();
    rst = 1; wr_en = 1; wr_addr = 0; wr_data = 9; sync = 1;
    step();
    rst = 0; idle_inputs(); en = 4'hF;
    checks++;
    if (tick !== 4'h0) begin failures++; $display("FAIL rst_mid_tick got=%h want=0", tick); end
    checks++;
    if (sq !== 4'h0) begin failures++; $display("FAIL rst_mid_sq got=%h want=0", sq); end
    for (int i = 1; i <= 4; i++) begin
      logic et;
      step();
      et = (i % 2 == 1);
      checks++;
      if (tick !== {NCH{et}}) begin failures++; $display("FAIL rst_mid_d2 cyc=%0d got=%h want=%h", i, tick, {NCH{et}}); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en      = NCH'($urandom_range(15, 0) | ($urandom_range(3, 0) == 0 ? 0 : 4'hC));
      wr_en   = ($urandom_range(7, 0) == 0);
      wr_addr = 2'($urandom_range(3, 0));
      wr_data = W'($urandom_range(6, 0));
      sync    = ($urandom_range(49, 0) == 0);
      step();
      checks++;
      if (tick !== m_tick || sq !== m_sq) begin
        failures++;
        $display("FAIL rand_model i=%0d tick=%h/%h sq=%h/%h", i, tick, m_tick, sq, m_sq);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pending_writes();
    test_sync();
    test_enable_hold();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logs_divider_bank.md
# logs_divider_bank

Bank of NCH independent, runtime-programmable clock dividers, each emitting a one-cycle tick once every D clocks plus a square wave of period 2·D. It is the parametrised successor to the fixed single-ratio tick generator and feeds timing strobes to downstream logic. Divisors are written through a simple register port and take effect glitch-free at the next wrap. A global sync strobe realigns all channels.

## Interface
- NCH, 4: number of channels (≥1).
- W, 16: divisor/counter width in bits.
- DIV_RST, 2: divisor loaded into every channel at reset (must fit in W bits).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  NCH  per-channel enable.
- wr_en  in  1  divisor write strobe.
- wr_addr  in  max(1,$clog2(NCH))  target channel; values ≥ NCH are ignored.
- wr_data  in  W  new divisor D.
- sync  in  1  realign all channels to phase 0.
- tick  out  NCH  per-channel one-cycle pulse, once every D enabled clocks.
- sq  out  NCH  per-channel square wave, toggles on each tick.

## Operation
- Per-channel state: cnt[W], div_act[W], div_pend[W], pend_vld, tick, sq.
- Effective divisor Deff = max(div_act, 1); D=0 behaves as D=1.
- Enabled and not syncing: tick <= (cnt==0); cnt <= (cnt ≥ Deff-1) ? 0 : cnt+1; sq toggles when cnt==0.
- On wrap (cnt ≥ Deff-1 while enabled) with pend_vld: div_act <= div_pend, pend_vld <= 0; new divisor governs the next period.
- Write to an enabled channel: div_pend <= wr_data, pend_vld <= 1; a second write before wrap overwrites pending (last write wins).
- Write to a disabled channel: div_act <= wr_data immediately, pend_vld <= 0, cnt <= 0.
- en low: cnt, sq, div_act hold; tick <= 0.
- sync (all channels, regardless of en): cnt <= 0, tick <= 0, sq <= 0, pending divisor promoted to div_act. Channel's first tick follows one enabled cycle later.
- wr_en with sync in the same cycle: written divisor goes straight into div_act for the addressed channel; pend_vld cleared.
- rst: cnt=0, div_act=DIV_RST, div_pend=0, pend_vld=0, tick=0, sq=0 for all channels; rst overrides sync and wr_en.

## Timing
- tick is registered: asserted in the cycle after the edge where cnt==0 was sampled.
- After rst deasserts with en high: tick high in cycle 1, then every Deff cycles (cycles 1, 1+D, 1+2D…).
- D=1 (or 0): tick constantly high while enabled; sq toggles every cycle.
- Divisor write latency: period in progress completes with old D; first period with new D starts at the wrap edge.
- sync latency: tick low in the cycle after sync; first tick the cycle after next (if en).
- cnt never exceeds Deff-1 after a wrap; if cnt ≥ Deff-1 (e.g. after immediate load on a disabled channel that was mid-count) the next enabled edge wraps to 0.

## Structure
- Sub-module logs_divider_chan: one channel (counter, active/pending divisor, tick, sq); bank instantiates NCH via generate and decodes wr_addr into per-channel write strobes.
- Shared package logs_pkg: default W, DIV_RST constants and the address-width function; no typedefs needed.
- No combinational path from inputs to outputs.

## Test plan
- Reset, en=all 1, default D=2: tick[0] high cycles 1,3,5…; sq[0] = 1,1,0,0,1,1… sampled after each tick edge.
- Channel 1 written D=5 while enabled mid-period (cnt=1 of D=2): remaining old period completes, then ticks every 5 cycles; pend_vld clears at wrap.
- Two writes (D=3 then D=7) before wrap on channel 2: only D=7 takes effect.
- sync asserted at arbitrary cycle with channels at different phases: all tick outputs low next cycle, all high together the cycle after, sq all 0.
- en[3] dropped for 4 cycles mid-count: tick[3] low, cnt/sq hold; resumes with exact remaining phase; write D=0 while disabled → tick every cycle after re-enable.
- rst asserted mid-operation together with wr_en and sync: all outputs 0 next cycle, div_act=DIV_RST, write discarded.
